fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 rst_f  in  1  asynchronous, active-low reset; asserted when low.
REQ-003 fetch_start  in  1  one-cycle pulse from control FSM requesting the next instruction.
REQ-004 br_taken  in  1  one-cycle pulse: redirect PC.
REQ-005 br_abs  in  1  1 = absolute target (PC <= br_imm); 0 = relative (PC <= PC + br_imm).
REQ-006 br_imm  in  16  branch target or signed offset.
REQ-007 imem_req  out  1  instruction memory request; held high until acknowledged.
REQ-008 imem_addr  out  16  word address, equals PC while imem_req is high.
REQ-009 imem_ack  in  1  memory acknowledge; imem_rdata valid in the same cycle.
REQ-010 imem_rdata  in  32  instruction word.
REQ-011 opcode, mm, rs, rt, rd  out  4 each  IR[31:28], IR[27:24], IR[23:20], IR[19:16], IR[15:12].
REQ-012 imm  out  16  IR[15:0].
REQ-013 pc  out  16  current program counter.
REQ-014 ir_valid  out  1  one-cycle pulse when a new instruction is loaded into IR.
REQ-015 busy  out  1  high in WAIT state or while a start is pending.
REQ-016 halted  out  1  sticky; set when an HLT (opcode 4'hF) instruction is loaded.
REQ-017 fetch_err  out  1  sticky; set on memory timeout.

Function
REQ-018 The FSM SHALL have two states: IDLE and WAIT. imem_req = 1 exactly in WAIT.
REQ-019 IDLE: fetch_start=1 (or pending=1) with halted=0 and fetch_err=0 -> WAIT next cycle; the timeout counter clears.
REQ-020 WAIT: imem_ack=1 -> IR <= imem_rdata, PC <= PC+1 (mod 2^16), ir_valid=1 next cycle, return to IDLE.
REQ-021 Latency: fetch_start at cycle N -> imem_req high at N+1; ack at cycle M -> ir_valid and the new fields visible at M+1.
REQ-022 Decoded outputs SHALL be driven directly from IR and SHALL be stable between loads.
REQ-023 Timeout counter, 8 bits: increments each WAIT cycle without ack. On the 255th such cycle -> fetch_err=1, return to IDLE; IR and PC unchanged.
REQ-024 br_taken is honoured in IDLE only. Relative arithmetic: 16-bit two's-complement add, wrap-around, no overflow flag.
REQ-025 br_taken in WAIT SHALL be ignored; the control FSM never issues it there.
REQ-026 br_taken and fetch_start in the same IDLE cycle: apply the branch first, set pending=1, then start the fetch the following cycle from the updated PC.
REQ-027 fetch_start in WAIT SHALL be ignored (no queuing).
REQ-028 IR loaded with opcode 4'hF -> halted=1 together with ir_valid; thereafter fetch_start and br_taken are ignored until reset.
REQ-029 fetch_err=1 -> fetch_start ignored until reset.
REQ-030 Ack arriving in the same cycle the counter reaches 255: the ack wins, the instruction is loaded, fetch_err stays 0.
REQ-031 imem_ack in IDLE SHALL be ignored.

Reset
REQ-032 rst_f low SHALL immediately force state=IDLE, PC=0, IR=0 (opcode=NOOP), pending=0, counter=0, imem_req=0, ir_valid=0, busy=0, halted=0, fetch_err=0.
REQ-033 Reset asserted in WAIT abandons the request; a late ack after release is ignored per REQ-031.
REQ-034 Outputs SHALL hold reset values until the first rising clk edge after rst_f returns high.

Verification
REQ-035 Basic fetch: reset, fetch_start, ack after 3 cycles with rdata=32'h81234005 -> imem_addr=0; ir_valid 1 cycle; opcode=8, mm=1, rs=2, rt=3, rd=4, imm=16'h4005; pc=1.
REQ-036 Relative branch: pc=16'h0005, br_taken, br_abs=0, br_imm=16'hFFFE -> pc=16'h0003. Absolute branch, br_imm=16'h00A0 -> pc=16'h00A0. Wrap case: pc=16'hFFFF, br_imm=1 relative -> pc=0.
REQ-037 Simultaneous: br_taken (abs 16'h0010) and fetch_start in the same cycle -> imem_req rises 2 cycles later with imem_addr=16'h0010.
REQ-038 Timeout: fetch_start, no ack -> fetch_err=1 after 255 WAIT cycles; pc unchanged; later fetch_start produces no imem_req. Boundary case: ack on cycle 255 -> normal load.
REQ-039 Halt: fetch returns 32'hF0000000 -> halted=1, opcode=F; subsequent fetch_start and br_taken have no effect.
REQ-040 Reset in WAIT: rst_f low mid-request -> imem_req drops without a clock edge; pc=0; a late ack produces no ir_valid.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch unit (master) and the memory (slave).
interface fetch_unit_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC, branch redirect, single outstanding memory request,
// instruction register with field decode, halt and timeout tracking.
module fetch_unit (
  input  logic         clk,
  input  logic         rst_f,
  fetch_unit_if.master imem,
  input  logic         fetch_start,
  input  logic         br_taken,
  input  logic         br_abs,
  input  logic [15:0]  br_imm,
  output logic [3:0]   opcode,
  output logic [3:0]   mm,
  output logic [3:0]   rs,
  output logic [3:0]   rt,
  output logic [3:0]   rd,
  output logic [15:0]  imm,
  output logic [15:0]  pc,
  output logic         ir_valid,
  output logic         busy,
  output logic         halted,
  output logic         fetch_err
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'd254;
  localparam logic [3:0] OP_HLT   = 4'hF;

  state_t      state;
  state_t      next_state;
  logic        pending;
  logic [7:0]  tmo_cnt;
  logic [31:0] ir;

  logic        start_ok;
  logic        br_go;
  logic        launch;
  logic        load;
  logic        timeout_hit;

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (launch) next_state = S_WAIT;
      S_WAIT: if (load || timeout_hit) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // A branch in the same cycle as a start defers the launch by one cycle
  // (via pending) so the request goes out with the redirected PC.
  always_comb begin
    imem.imem_req = 1'b0;
    busy          = pending;
    br_go         = 1'b0;
    launch        = 1'b0;
    load          = 1'b0;
    timeout_hit   = 1'b0;
    start_ok      = (fetch_start || pending) && !halted && !fetch_err;
    case (state)
      S_IDLE: begin
        br_go  = br_taken && !halted;
        launch = start_ok && !br_go;
      end
      S_WAIT: begin
        imem.imem_req = 1'b1;
        busy          = 1'b1;
        load          = imem.imem_ack;
        timeout_hit   = !imem.imem_ack && (tmo_cnt == TMO_LAST);
      end
      default: begin
        imem.imem_req = 1'b0;
      end
    endcase
  end

  assign imem.imem_addr = pc;

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      pc        <= 16'h0000;
      ir        <= 32'h0000_0000;
      pending   <= 1'b0;
      tmo_cnt   <= 8'd0;
      ir_valid  <= 1'b0;
      halted    <= 1'b0;
      fetch_err <= 1'b0;
    end else begin
      ir_valid <= load;
      pending  <= br_go && start_ok;

      if (br_go) begin
        pc <= br_abs ? br_imm : (pc + br_imm);
      end else if (load) begin
        pc <= pc + 16'd1;
      end

      if (load) begin
        ir <= imem.imem_rdata;
      end

      if (launch) begin
        tmo_cnt <= 8'd0;
      end else if ((state == S_WAIT) && !imem.imem_ack) begin
        tmo_cnt <= tmo_cnt + 8'd1;
      end

      if (load && (imem.imem_rdata[31:28] == OP_HLT)) begin
        halted <= 1'b1;
      end

      if (timeout_hit) begin
        fetch_err <= 1'b1;
      end
    end
  end

  assign opcode = ir[31:28];
  assign mm     = ir[27:24];
  assign rs     = ir[23:20];
  assign rt     = ir[19:16];
  assign rd     = ir[15:12];
  assign imm    = ir[15:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic compared
// cycle by cycle against a procedural reference model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_f;
  logic        fetch_start;
  logic        br_taken;
  logic        br_abs;
  logic [15:0] br_imm;
  logic [3:0]  opcode, mm, rs, rt, rd;
  logic [15:0] imm, pc;
  logic        ir_valid, busy, halted, fetch_err;

  fetch_unit_if imem_bus ();

  fetch_unit dut (
    .clk         (clk),
    .rst_f       (rst_f),
    .imem        (imem_bus),
    .fetch_start (fetch_start),
    .br_taken    (br_taken),
    .br_abs      (br_abs),
    .br_imm      (br_imm),
    .opcode      (opcode),
    .mm          (mm),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .imm         (imm),
    .pc          (pc),
    .ir_valid    (ir_valid),
    .busy        (busy),
    .halted      (halted),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  int vec_count = 0;
  int err_count = 0;

  // Reference model state
  bit          m_wait, m_pending, m_halted, m_err, m_valid;
  int          m_wait_cycles;
  logic [15:0] m_pc;
  logic [31:0] m_ir;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_count++;
    if (got !== exp) begin
      err_count++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_wait = 0; m_pending = 0; m_halted = 0; m_err = 0; m_valid = 0;
    m_wait_cycles = 0; m_pc = 16'h0; m_ir = 32'h0;
  endtask

  task automatic modelStep(input bit fs, input bit bt, input bit ba, input logic [15:0] bi,
                           input bit ack, input logic [31:0] rdat);
    bit want, br;
    m_valid = 0;
    if (!m_wait) begin
      want = (fs || m_pending) && !m_halted && !m_err;
      br   = bt && !m_halted;
      if (br) m_pc = ba ? bi : 16'(m_pc + bi);
      if (want && br) begin
        m_pending = 1;
      end else begin
        m_pending = 0;
        if (want) begin
          m_wait = 1;
          m_wait_cycles = 0;
        end
      end
    end else if (ack) begin
      m_ir = rdat;
      m_pc = m_pc + 16'd1;
      m_valid = 1;
      if (rdat[31:28] == 4'hF) m_halted = 1;
      m_wait = 0;
    end else begin
      m_wait_cycles++;
      if (m_wait_cycles == 255) begin
        m_err = 1;
        m_wait = 0;
      end
    end
  endtask

  task automatic compareAll();
    checkOutput("imem_req", imem_bus.imem_req, m_wait);
    if (m_wait) checkOutput("imem_addr", imem_bus.imem_addr, m_pc);
    checkOutput("pc", pc, m_pc);
    checkOutput("ir_valid", ir_valid, m_valid);
    checkOutput("opcode", opcode, m_ir[31:28]);
    checkOutput("mm", mm, m_ir[27:24]);
    checkOutput("rs", rs, m_ir[23:20]);
    checkOutput("rt", rt, m_ir[19:16]);
    checkOutput("rd", rd, m_ir[15:12]);
    checkOutput("imm", imm, m_ir[15:0]);
    checkOutput("busy", busy, m_wait || m_pending);
    checkOutput("halted", halted, m_halted);
    checkOutput("fetch_err", fetch_err, m_err);
  endtask

  // Called at a falling edge; drives one cycle of inputs and checks the result.
  task automatic applyStimulus(input bit fs, input bit bt, input bit ba, input logic [15:0] bi,
                               input bit ack, input logic [31:0] rdat);
    fetch_start = fs;
    br_taken    = bt;
    br_abs      = ba;
    br_imm      = bi;
    imem_bus.imem_ack   = ack;
    imem_bus.imem_rdata = rdat;
    @(posedge clk);
    if (rst_f) modelStep(fs, bt, ba, bi, ack, rdat);
    @(negedge clk);
    compareAll();
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 0, 16'h0, 0, 32'h0);
  endtask

  // Asynchronous reset pulse starting at a falling edge, checked before any clock edge.
  task automatic doReset();
    rst_f = 1'b0;
    #1;
    modelReset();
    checkOutput("rst_async_req", imem_bus.imem_req, 0);
    checkOutput("rst_async_pc", pc, 0);
    compareAll();
    fetch_start = 0; br_taken = 0; br_abs = 0; br_imm = 0;
    imem_bus.imem_ack = 0; imem_bus.imem_rdata = 0;
    @(negedge clk);
    compareAll();
    rst_f = 1'b1;
  endtask

  initial begin
    int req_cycles;
    int guard;
    bit fs, bt, ack;
    int ack_pct;

    rst_f = 1'b0;
    fetch_start = 0; br_taken = 0; br_abs = 0; br_imm = 0;
    imem_bus.imem_ack = 0; imem_bus.imem_rdata = 0;
    modelReset();
    @(negedge clk);
    doReset();

    // Basic fetch with a three-cycle memory latency
    applyStimulus(1, 0, 0, 16'h0, 0, 32'h0);
    checkOutput("basic_req", imem_bus.imem_req, 1);
    checkOutput("basic_addr", imem_bus.imem_addr, 16'h0000);
    idleCycle();
    idleCycle();
    applyStimulus(0, 0, 0, 16'h0, 1, 32'h8123_4005);
    checkOutput("basic_valid", ir_valid, 1);
    checkOutput("basic_opcode", opcode, 4'h8);
    checkOutput("basic_mm", mm, 4'h1);
    checkOutput("basic_rs", rs, 4'h2);
    checkOutput("basic_rt", rt, 4'h3);
    checkOutput("basic_rd", rd, 4'h4);
    checkOutput("basic_imm", imm, 16'h4005);
    checkOutput("basic_pc", pc, 16'h0001);
    idleCycle();
    checkOutput("basic_valid_pulse", ir_valid, 0);
    checkOutput("basic_opcode_hold", opcode, 4'h8);

    // Branches: relative negative, absolute, relative wrap
    applyStimulus(0, 1, 1, 16'h0005, 0, 32'h0);
    applyStimulus(0, 1, 0, 16'hFFFE, 0, 32'h0);
    checkOutput("br_rel", pc, 16'h0003);
    applyStimulus(0, 1, 1, 16'h00A0, 0, 32'h0);
    checkOutput("br_abs", pc, 16'h00A0);
    applyStimulus(0, 1, 1, 16'hFFFF, 0, 32'h0);
    applyStimulus(0, 1, 0, 16'h0001, 0, 32'h0);
    checkOutput("br_wrap", pc, 16'h0000);

    // Branch and start together: request launches one cycle later from the new PC
    applyStimulus(1, 1, 1, 16'h0010, 0, 32'h0);
    checkOutput("sim_req_early", imem_bus.imem_req, 0);
    checkOutput("sim_busy", busy, 1);
    idleCycle();
    checkOutput("sim_req", imem_bus.imem_req, 1);
    checkOutput("sim_addr", imem_bus.imem_addr, 16'h0010);
    applyStimulus(1, 1, 1, 16'h0777, 1, 32'h1234_5678);
    checkOutput("sim_pc", pc, 16'h0011);

    // Timeout: exactly 255 request cycles, then sticky error
    @(negedge clk);
    doReset();
    applyStimulus(1, 0, 0, 16'h0, 0, 32'h0);
    req_cycles = imem_bus.imem_req ? 1 : 0;
    guard = 0;
    while (imem_bus.imem_req && guard < 400) begin
      idleCycle();
      if (imem_bus.imem_req) req_cycles++;
      guard++;
    end
    checkOutput("tmo_cycles", req_cycles, 255);
    checkOutput("tmo_err", fetch_err, 1);
    checkOutput("tmo_pc", pc, 16'h0000);
    applyStimulus(1, 0, 0, 16'h0, 0, 32'h0);
    checkOutput("tmo_no_req", imem_bus.imem_req, 0);

    // Ack on the 255th waiting cycle wins over the timeout
    doReset();
    applyStimulus(1, 0, 0, 16'h0, 0, 32'h0);
    for (int i = 0; i < 254; i++) idleCycle();
    applyStimulus(0, 0, 0, 16'h0, 1, 32'h2345_6789);
    checkOutput("tmo_edge_valid", ir_valid, 1);
    checkOutput("tmo_edge_err", fetch_err, 0);
    checkOutput("tmo_edge_pc", pc, 16'h0001);

    // Halt instruction freezes fetch and branches
    doReset();
    applyStimulus(1, 0, 0, 16'h0, 0, 32'h0);
    applyStimulus(0, 0, 0, 16'h0, 1, 32'hF000_0000);
    checkOutput("hlt_halted", halted, 1);
    checkOutput("hlt_opcode", opcode, 4'hF);
    applyStimulus(1, 0, 0, 16'h0, 0, 32'h0);
    checkOutput("hlt_no_req", imem_bus.imem_req, 0);
    applyStimulus(0, 1, 1, 16'h0055, 0, 32'h0);
    checkOutput("hlt_no_br", pc, 16'h0001);

    // Reset mid-request; a late ack must be ignored
    doReset();
    applyStimulus(0, 1, 1, 16'h0077, 0, 32'h0);
    applyStimulus(1, 0, 0, 16'h0, 0, 32'h0);
    checkOutput("rstw_req_before", imem_bus.imem_req, 1);
    doReset();
    applyStimulus(0, 0, 0, 16'h0, 1, 32'h3333_3333);
    checkOutput("rstw_late_ack", ir_valid, 0);
    checkOutput("rstw_pc", pc, 16'h0000);

    // Randomized traffic with periodic resets
    ack_pct = 25;
    for (int i = 0; i < 3000; i++) begin
      if (i % 400 == 399) begin
        doReset();
        ack_pct = ($urandom_range(0, 3) == 0) ? 1 : 25;
      end
      fs  = ($urandom_range(0, 2) == 0);
      bt  = ($urandom_range(0, 5) == 0);
      ack = ($urandom_range(0, 99) < ack_pct);
      begin
        logic [31:0] rdat;
        rdat = $urandom;
        if (rdat[31:28] == 4'hF && $urandom_range(0, 9) != 0) rdat[31:28] = 4'h7;
        applyStimulus(fs, bt, 1'($urandom_range(0, 1)), 16'($urandom), ack, rdat);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
